incubator_temp_sensor_if: RTL and testbench
===========================================

Name: incubator_temp_sensor_if

Overview:
Sensor front end that produces the 8-bit temperature consumed by the incubator heater/cooler/fan controller. It periodically reads a 16-bit frame from a serial (SPI mode 0, read-only) digital temperature sensor, decodes and clamps the reading, and presents a held unsigned temperature with a one-cycle valid strobe. It also flags faults. It sits between the sensor pins and the control FSM's temperature input.

Parameters:
CLK_DIV, 2, clk cycles per sclk half-period (>=1)
SAMPLE_PERIOD, 1000, clk cycles between conversion starts (must exceed frame length 2*CLK_DIV+32*CLK_DIV+1)
RESET_TEMP, 30, temperature output value after reset (inside the controller's idle band 25..36)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  allow new conversions
sensor_miso  in  1  serial data from sensor (pre-synchronised at top level)
sensor_sclk  out  1  serial clock, idle low
sensor_cs_n  out  1  chip select, active low
temperature  out  8  last good reading, unsigned °C, held between updates
temp_valid  out  1  one-cycle pulse when temperature updated
sensor_fault  out  1  high after a bad frame; cleared by next good frame
busy  out  1  high while a frame is in progress (not IDLE)

Behaviour:
- Reset (async): state IDLE, sensor_cs_n=1, sensor_sclk=0, temperature=RESET_TEMP, temp_valid=0, sensor_fault=0, busy=0, sample counter=0, shift register=0.
- Sample counter runs freely 0..SAMPLE_PERIOD-1, wraps. Tick = counter at SAMPLE_PERIOD-1. First tick occurs SAMPLE_PERIOD cycles after reset release.
- Tick with enable=1 in IDLE starts a frame. A tick in any other state, or with enable=0, is dropped; no queuing.
- FSM states:
  - IDLE: cs_n=1, sclk=0.
  - CS_SETUP: cs_n=0 for CLK_DIV cycles, then SHIFT.
  - SHIFT: sclk toggles every CLK_DIV cycles, starting low. There are 16 rising edges. miso is sampled into the shift register MSB-first in the clk cycle where sclk rises. After the 16th high phase, sclk returns low and the FSM goes to CS_HOLD.
  - CS_HOLD: cs_n=1 for CLK_DIV cycles.
  - UPDATE: 1 cycle, then IDLE.
- Frame length: CLK_DIV + 32*CLK_DIV + CLK_DIV + 1 cycles (69 for CLK_DIV=2).
- Frame decode (frame[15:0]):
  - frame[15:8] = signed two's-complement integer °C.
  - frame[7:1] = fraction, ignored.
  - frame[0] = sensor fault bit.
- Bad frame: frame[0]=1 or frame==16'hFFFF (bus stuck high). In UPDATE: sensor_fault<=1, temperature held, no temp_valid.
- Good frame: in UPDATE, sensor_fault<=0 and temp_valid pulses for 1 cycle. temperature is registered on that same cycle:
  - 0 if frame[15]=1 (negative clamps to 0).
  - frame[15:8] otherwise (range 0..127).
- enable dropping mid-frame: the current frame completes normally, including UPDATE. No truncated transactions.
- Reset mid-frame: cs_n=1 and sclk=0 immediately; the partial frame is discarded.
- temperature changes only in UPDATE or reset.

Decomposition:
- Shared package incubator_pkg holds:
  - state encoding constants
  - frame field positions (TEMP_MSB=15, TEMP_LSB=8, FAULT_BIT=0)
  - FRAME_BITS=16
  - STUCK_HIGH=16'hFFFF
  - default RESET_TEMP
- One natural sub-module, incubator_spi_rx_shift: sclk half-period divider, edge counter, and MSB-first shift register. It exposes start/done/frame[15:0]. The parent keeps the sample counter, FSM, decode and output registers.

Test Plan:
- Reset then idle, enable=0, 3*SAMPLE_PERIOD cycles -> cs_n stays 1, sclk 0, temperature=30, temp_valid never pulses.
- CLK_DIV=2, SAMPLE_PERIOD=100, enable=1, sensor model frame 16'h1C00 (28 °C) -> cs_n low 64+ cycles, 16 sclk rises, temp_valid single pulse, temperature=28. Repeat with 16'h2500 -> 37.
- Negative reading 16'hF600 (-10 °C) -> temperature=0, temp_valid pulses, sensor_fault=0.
- Fault frame 16'h1801 then MISO stuck high (16'hFFFF) -> sensor_fault=1, temperature holds previous 28, no temp_valid. Next good frame 16'h1E00 -> sensor_fault=0, temperature=30, temp_valid pulses.
- Deassert enable 10 cycles into a frame -> frame completes and updates. No further frames until enable returns, then the next start coincides with the counter tick.
- Assert rst during SHIFT at the 8th sclk rise -> cs_n=1 and sclk=0 in the same cycle, temperature=30, busy=0. The next frame starts SAMPLE_PERIOD cycles after release.

Source files
------------

// File: rtl/incubator_pkg.sv
// Shared definitions for the incubator temperature sensor front end:
// FSM encoding, sensor frame layout and frame decode helpers.
package incubator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_UPDATE
  } state_e;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned TEMP_MSB   = 15;
  localparam int unsigned TEMP_LSB   = 8;
  localparam int unsigned FAULT_BIT  = 0;

  localparam logic [FRAME_BITS-1:0] STUCK_HIGH         = 16'hFFFF;
  localparam logic [7:0]            DEFAULT_RESET_TEMP = 8'd30;

  // Sensor-reported fault, or a frame of all ones from a floating/stuck MISO line.
  function automatic logic frame_is_bad(input logic [FRAME_BITS-1:0] frame);
    return frame[FAULT_BIT] || (frame == STUCK_HIGH);
  endfunction

  // Signed integer degrees in, unsigned degrees out; sub-zero readings clamp to 0.
  function automatic logic [7:0] clamp_temp(input logic [7:0] temp_int);
    return temp_int[7] ? 8'd0 : temp_int;
  endfunction

endpackage

// File: rtl/incubator_spi_rx_shift.sv
// SPI mode-0 receive engine: 16 sclk periods of 2*CLK_DIV clk cycles each,
// capturing MISO MSB-first on every sclk rise.
module incubator_spi_rx_shift
  import incubator_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  done_c,
  output logic [FRAME_BITS-1:0] frame
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HALVES = 2 * FRAME_BITS;
  localparam int unsigned HALF_W = $clog2(HALVES);

  logic              active;
  logic [DIV_W-1:0]  div_cnt;
  logic [HALF_W-1:0] half_cnt;
  logic              phase_end_c;

  assign phase_end_c = active && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign done_c      = phase_end_c && (half_cnt == HALF_W'(HALVES - 1));

  // Half-period divider; sclk toggles at each phase end and returns low after the last high phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= 1'b0;
      div_cnt  <= '0;
      half_cnt <= '0;
      sclk     <= 1'b0;
      frame    <= '0;
    end else if (start) begin
      active   <= 1'b1;
      div_cnt  <= '0;
      half_cnt <= '0;
      sclk     <= 1'b0;
      frame    <= '0;
    end else if (phase_end_c) begin
      div_cnt <= '0;
      if (done_c) begin
        active <= 1'b0;
        sclk   <= 1'b0;
      end else begin
        half_cnt <= half_cnt + HALF_W'(1);
        sclk     <= ~sclk;
        if (!sclk) frame <= {frame[FRAME_BITS-2:0], miso};
      end
    end else if (active) begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/incubator_temp_sensor_if.sv
// Periodic SPI temperature sensor reader: frames the conversion, decodes and clamps
// the reading, and holds the last good temperature for the heater/cooler controller.
module incubator_temp_sensor_if
  import incubator_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned SAMPLE_PERIOD = 1000,
  parameter logic [7:0]  RESET_TEMP    = DEFAULT_RESET_TEMP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       sensor_miso,
  output logic       sensor_sclk,
  output logic       sensor_cs_n,
  output logic [7:0] temperature,
  output logic       temp_valid,
  output logic       sensor_fault,
  output logic       busy
);

  localparam int unsigned SMP_W = $clog2(SAMPLE_PERIOD);
  localparam int unsigned PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_e                state;
  logic [SMP_W-1:0]      smp_cnt;
  logic [PH_W-1:0]       ph_cnt;
  logic                  tick_c;
  logic                  ph_end_c;
  logic                  shift_start_c;
  logic                  shift_done_c;
  logic [FRAME_BITS-1:0] frame;

  assign tick_c        = (smp_cnt == SMP_W'(SAMPLE_PERIOD - 1));
  assign ph_end_c      = (ph_cnt == PH_W'(CLK_DIV - 1));
  assign shift_start_c = (state == ST_CS_SETUP) && ph_end_c;

  // Free-running conversion timer, independent of enable and FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         smp_cnt <= '0;
    else if (tick_c) smp_cnt <= '0;
    else             smp_cnt <= smp_cnt + SMP_W'(1);
  end

  incubator_spi_rx_shift #(
    .CLK_DIV (CLK_DIV)
  ) u_rx (
    .clk    (clk),
    .rst    (rst),
    .start  (shift_start_c),
    .miso   (sensor_miso),
    .sclk   (sensor_sclk),
    .done_c (shift_done_c),
    .frame  (frame)
  );

  // Frame sequencer; cs_n and busy are registered alongside the state they mirror.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      ph_cnt       <= '0;
      sensor_cs_n  <= 1'b1;
      temperature  <= RESET_TEMP;
      temp_valid   <= 1'b0;
      sensor_fault <= 1'b0;
      busy         <= 1'b0;
    end else begin
      temp_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (tick_c && enable) begin
            state       <= ST_CS_SETUP;
            ph_cnt      <= '0;
            sensor_cs_n <= 1'b0;
            busy        <= 1'b1;
          end
        end
        ST_CS_SETUP: begin
          if (ph_end_c) begin
            state  <= ST_SHIFT;
            ph_cnt <= '0;
          end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end
        end
        ST_SHIFT: begin
          if (shift_done_c) begin
            state       <= ST_CS_HOLD;
            ph_cnt      <= '0;
            sensor_cs_n <= 1'b1;
          end
        end
        ST_CS_HOLD: begin
          if (ph_end_c) begin
            state <= ST_UPDATE;
            if (frame_is_bad(frame)) begin
              sensor_fault <= 1'b1;
            end else begin
              sensor_fault <= 1'b0;
              temp_valid   <= 1'b1;
              temperature  <= clamp_temp(frame[TEMP_MSB:TEMP_LSB]);
            end
          end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end
        end
        ST_UPDATE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state       <= ST_IDLE;
          sensor_cs_n <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_incubator_temp_sensor_if.sv
// Bench for incubator_temp_sensor_if: behavioural SPI sensor, directed and random
// frames, enable drop and reset mid-frame, checked against a frame-level model.
module tb_incubator_temp_sensor_if;

  localparam int CLK_DIV    = 2;
  localparam int SP         = 100;
  localparam int FRAME_CYC  = 2 * CLK_DIV + 32 * CLK_DIV + 1;
  localparam int CS_LOW_CYC = 33 * CLK_DIV;
  localparam int RST_TEMP   = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       sensor_miso;
  logic       sensor_sclk;
  logic       sensor_cs_n;
  logic [7:0] temperature;
  logic       temp_valid;
  logic       sensor_fault;
  logic       busy;

  logic [15:0] sensor_word = 16'h0000;
  logic [15:0] rw;
  logic [15:0] dir [7] = '{16'h1C00, 16'h2500, 16'hF600, 16'h1C00, 16'h1801, 16'hFFFF, 16'h1E00};
  int sens_idx = 0;

  int cyc = 0;
  int mon_cs_low = 0, mon_cs_fall = 0, mon_rise = 0, mon_valid = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0;
  int s_cs, s_r, s_v, s_f;
  int n_checks = 0, n_err = 0;
  int c0 = 0;
  int model_temp = RST_TEMP;
  int model_fault = 0;
  int st, rises;
  logic pv;

  always #5 clk = ~clk;

  incubator_temp_sensor_if #(
    .CLK_DIV       (CLK_DIV),
    .SAMPLE_PERIOD (SP),
    .RESET_TEMP    (8'(RST_TEMP))
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sensor_miso  (sensor_miso),
    .sensor_sclk  (sensor_sclk),
    .sensor_cs_n  (sensor_cs_n),
    .temperature  (temperature),
    .temp_valid   (temp_valid),
    .sensor_fault (sensor_fault),
    .busy         (busy)
  );

  // Sensor: MSB presented at CS fall, next bit after each sclk fall, ones once exhausted.
  always @(negedge sensor_sclk or posedge sensor_cs_n) begin
    if (sensor_cs_n) sens_idx <= 0;
    else             sens_idx <= sens_idx + 1;
  end
  assign sensor_miso = (sens_idx < 16) ? sensor_word[4'(15 - sens_idx)] : 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!sensor_cs_n) mon_cs_low++;
    if (prev_cs && !sensor_cs_n) mon_cs_fall++;
    if (!prev_sclk && sensor_sclk) mon_rise++;
    if (temp_valid) mon_valid++;
    prev_cs   = sensor_cs_n;
    prev_sclk = sensor_sclk;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic take_snap();
    s_cs = mon_cs_low;
    s_r  = mon_rise;
    s_v  = mon_valid;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_temp  = RST_TEMP;
    model_fault = 0;
    #1;
    check("rst_cs_n", int'(sensor_cs_n), 1);
    check("rst_sclk", int'(sensor_sclk), 0);
    check("rst_temp", int'(temperature), model_temp);
    check("rst_valid", int'(temp_valid), 0);
    check("rst_fault", int'(sensor_fault), model_fault);
    check("rst_busy", int'(busy), 0);
    step();
    step();
    rst = 1'b0;
    c0 = cyc;
  endtask

  // Frame-level expectation: good frames update and clamp, bad frames only raise fault.
  task automatic model_update(input logic [15:0] w, output int exp_v);
    int t;
    if (w[0] || w == 16'hFFFF) begin
      model_fault = 1;
      exp_v = 0;
    end else begin
      t = $signed(w[15:8]);
      model_fault = 0;
      model_temp  = (t < 0) ? 0 : t;
      exp_v = 1;
    end
  endtask

  // Next start lands on the first sample tick after now (ticks every SP cycles from release).
  task automatic wait_start(output int start_cyc);
    int exp_start;
    exp_start = c0 + ((cyc - c0) / SP + 1) * SP;
    for (int i = 0; i < 3 * SP && sensor_cs_n; i++) step();
    if (sensor_cs_n) begin
      check("start_timeout", int'(sensor_cs_n), 0);
      start_cyc = -1;
    end else begin
      start_cyc = cyc;
      check("start_cyc", cyc, exp_start);
      check("busy_start", int'(busy), 1);
    end
  endtask

  task automatic finish_frame(input int start_cyc, input logic [15:0] w);
    int exp_v;
    for (int i = 0; i < FRAME_CYC + 10 && busy; i++) step();
    check("busy_end", int'(busy), 0);
    check("frame_len", cyc - start_cyc, FRAME_CYC);
    check("cs_low_cyc", mon_cs_low - s_cs, CS_LOW_CYC);
    check("sclk_rises", mon_rise - s_r, 16);
    model_update(w, exp_v);
    check("valid_pulses", mon_valid - s_v, exp_v);
    check("temperature", int'(temperature), model_temp);
    check("fault", int'(sensor_fault), model_fault);
  endtask

  task automatic run_frame(input logic [15:0] w);
    int sc;
    sensor_word = w;
    take_snap();
    wait_start(sc);
    if (sc >= 0) finish_frame(sc, w);
  endtask

  initial begin
    #1;
    apply_reset();

    // Idle with conversions disabled
    s_f = mon_cs_fall;
    s_v = mon_valid;
    repeat (3 * SP) step();
    check("idle_cs_falls", mon_cs_fall - s_f, 0);
    check("idle_valid", mon_valid - s_v, 0);
    check("idle_cs_n", int'(sensor_cs_n), 1);
    check("idle_sclk", int'(sensor_sclk), 0);
    check("idle_temp", int'(temperature), RST_TEMP);

    enable = 1'b1;
    foreach (dir[k]) run_frame(dir[k]);

    for (int i = 0; i < 12; i++) begin
      rw = 16'($urandom);
      case (i % 4)
        0: rw[0] = 1'b0;
        1: begin rw[15] = 1'b1; rw[0] = 1'b0; end
        2: rw[0] = 1'b1;
        default: rw = (i == 3) ? 16'hFFFF : {1'b0, rw[14:1], 1'b0};
      endcase
      run_frame(rw);
    end

    // Enable dropped mid-frame: frame still completes, then no starts until re-enabled
    sensor_word = 16'h1400;
    take_snap();
    wait_start(st);
    if (st >= 0) begin
      repeat (10) step();
      enable = 1'b0;
      finish_frame(st, 16'h1400);
    end
    enable = 1'b0;
    s_f = mon_cs_fall;
    repeat (3 * SP) step();
    check("disabled_no_start", mon_cs_fall - s_f, 0);
    enable = 1'b1;
    run_frame(16'h2200);

    // Reset on the 8th sclk rise
    sensor_word = 16'h3000;
    take_snap();
    wait_start(st);
    rises = 0;
    pv = sensor_sclk;
    for (int i = 0; i < FRAME_CYC && rises < 8; i++) begin
      step();
      if (sensor_sclk && !pv) rises++;
      pv = sensor_sclk;
    end
    check("rises_before_rst", rises, 8);
    apply_reset();
    run_frame(16'h1C00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
